dsm_frac_div: RTL and testbench
===============================

# dsm_frac_div

Fractional-N clock divider that consumes the 5-bit signed output of the DSM core and turns it into a sequence of divide ratios. Each output period lasts N = n_int + dsm_in clock cycles. At every period boundary the block pulses dsm_adv, which advances the modulator by one sample, so the long-run average ratio equals n_int plus the DSM's fractional mean. It sits directly downstream of the DSM core, and its output pulse feeds the PLL phase-detector path.

## Interface
Parameters:
- CNT_W, 8, width of the integer ratio, period counter and period_o
- DSM_W, 5, width of the two's-complement DSM sample
- N_MIN, 2, minimum legal period in clk cycles (must be ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run/stop; level-sensitive
- n_int  in  CNT_W  unsigned integer divide ratio; sampled only at a reload
- dsm_in  in  DSM_W  signed DSM sample (nominal range −3..+4); sampled only at a reload
- clr_flag  in  1  one-cycle pulse that clears clamp_flag
- dsm_adv  out  1  registered one-cycle strobe: advance the DSM by one sample
- div_out  out  1  registered one-cycle pulse at each period start
- period_o  out  CNT_W  last loaded period P
- clamp_flag  out  1  sticky: a computed period was clamped
- busy  out  1  high in LOAD or COUNT

## Operation
- States: IDLE, LOAD, COUNT.
  - IDLE → LOAD when enable = 1.
  - LOAD → COUNT unconditionally.
  - COUNT → IDLE when enable = 0, checked before any reload.
  - LOAD or COUNT → IDLE on enable = 0.
- Period arithmetic:
  - sum = zero-extended n_int + sign-extended dsm_in, computed at CNT_W+2 bits signed.
  - If sum < N_MIN: P = N_MIN and clamp_flag is set.
  - If sum > 2^CNT_W − 1: P = 2^CNT_W − 1 and clamp_flag is set.
  - Otherwise P = sum.
- Reload event: happens in LOAD, and in COUNT when cnt == 0 while enable = 1. A reload does all of the following on one edge:
  - cnt <= P − 1 and period_o <= P.
  - div_out <= 1 and dsm_adv <= 1.
  - On all other edges, div_out and dsm_adv are 0.
- COUNT with cnt ≠ 0: cnt <= cnt − 1.
- DSM contract: upstream updates dsm_in on the edge where it samples dsm_adv = 1. Because N_MIN ≥ 2, the new sample is stable at least one cycle before the next reload.
- clamp_flag: set on a clamped reload. If a set and a clr_flag arrive on the same edge, the set wins.
- Entering IDLE: cnt <= 0, div_out and dsm_adv <= 0. period_o and clamp_flag hold their values.
- reset (asynchronous, active-low):
  - State = IDLE and cnt = 0.
  - dsm_adv = 0, div_out = 0, period_o = 0, clamp_flag = 0, busy = 0.
  - Reset asserted mid-period aborts the period immediately, with no trailing pulse.

## Timing
- enable is sampled high at edge e0 → LOAD. At edge e1 the first reload occurs, so div_out and dsm_adv are high during the cycle after e1.
- Subsequent div_out pulses are exactly P cycles apart, where P is the value computed at the previous reload.
- dsm_adv is coincident with div_out on every pulse.
- busy is registered and follows the state (high from the cycle after e0).
- enable sampled low in COUNT → IDLE on that edge, with no further pulses. If that edge would have been a reload, no reload occurs.
- Latency from dsm_in to its effect on the period: one reload, i.e. a sample fetched by dsm_adv sets the period that follows the next div_out.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE = 2'd0, LOAD = 2'd1, COUNT = 2'd2.
  - defaults for CNT_W, DSM_W and N_MIN.
  - the DSM_FRAC_DIV Wishbone address constants, for a later CPU wrapper.
- One sub-module, dsm_period_calc: a combinational sign-extend/add/clamp block with outputs P and clamp_hit. Everything else (FSM, counter, strobes, flag) stays in dsm_frac_div.

## Test plan
- n_int = 10, dsm_in held at 0, enable raised → first div_out 2 cycles after enable is sampled, then a pulse every 10 cycles; dsm_adv coincident; period_o = 10; clamp_flag = 0.
- n_int = 8, dsm_in alternating +1/−1, updated on each dsm_adv → periods 9, 7, 9, 7…; average over 100 pulses is 8.
- n_int = 4, dsm_in = −3 → P = 2 (clamped), clamp_flag = 1. A clr_flag pulse on the same edge as a clamped reload leaves the flag at 1; a later clr_flag clears it.
- n_int = 254, dsm_in = +4 → P = 255 (clamped), period_o = 255, clamp_flag = 1.
- enable dropped with cnt = 3 → IDLE on the next edge, no further div_out/dsm_adv, busy = 0; re-enable gives a fresh first period.
- reset asserted asynchronously mid-count → all outputs 0 immediately; after release, the block stays in IDLE until enable is sampled high.

Source files
------------

// File: rtl/dsm_frac_div_pkg.sv
// dsm_frac_div_pkg: shared state encoding, parameter defaults and bus addresses for the fractional divider
package dsm_frac_div_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_e;
    localparam int CNT_W_DEF = 8;
    localparam int DSM_W_DEF = 5;
    localparam int N_MIN_DEF = 2;
    // Register map reserved for the future CPU-facing Wishbone wrapper
    localparam logic [7:0] DSM_FRAC_DIV_WB_CTRL   = 8'h00;
    localparam logic [7:0] DSM_FRAC_DIV_WB_NINT   = 8'h04;
    localparam logic [7:0] DSM_FRAC_DIV_WB_PERIOD = 8'h08;
    localparam logic [7:0] DSM_FRAC_DIV_WB_STATUS = 8'h0C;
endpackage

// File: rtl/dsm_period_calc.sv
// dsm_period_calc: adds the signed DSM sample to the integer ratio and clamps to the legal period range
module dsm_period_calc
    import dsm_frac_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DSM_W = DSM_W_DEF,
    parameter int N_MIN = N_MIN_DEF
) (
    input  logic [CNT_W-1:0] n_int,
    input  logic [DSM_W-1:0] dsm_in,
    output logic [CNT_W-1:0] p,
    output logic             clamp_hit
);
    localparam logic signed [CNT_W+1:0] MIN_S = (CNT_W+2)'(N_MIN);
    localparam logic signed [CNT_W+1:0] MAX_S = (CNT_W+2)'((1 << CNT_W) - 1);
    logic signed [CNT_W+1:0] sum;
    logic lo, hi;
    assign sum       = $signed({2'b00, n_int}) + $signed({{(CNT_W+2-DSM_W){dsm_in[DSM_W-1]}}, dsm_in});
    assign lo        = sum < MIN_S;
    assign hi        = sum > MAX_S;
    assign clamp_hit = lo | hi;
    assign p         = lo ? CNT_W'(N_MIN) : hi ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
endmodule

// File: rtl/dsm_frac_div.sv
// dsm_frac_div: fractional-N divider; each period lasts n_int + dsm_in cycles and advances the DSM once
module dsm_frac_div
    import dsm_frac_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DSM_W = DSM_W_DEF,
    parameter int N_MIN = N_MIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] n_int,
    input  logic [DSM_W-1:0] dsm_in,
    input  logic             clr_flag,
    output logic             dsm_adv,
    output logic             div_out,
    output logic [CNT_W-1:0] period_o,
    output logic             clamp_flag,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, p;
    logic             strobe_q, strobe_d, flag_q, flag_d, busy_q, clamp_hit, reload;

    dsm_period_calc #(.CNT_W(CNT_W), .DSM_W(DSM_W), .N_MIN(N_MIN)) u_calc (
        .n_int     (n_int),
        .dsm_in    (dsm_in),
        .p         (p),
        .clamp_hit (clamp_hit)
    );

    // enable low wins over a pending reload, so a stop never emits a final pulse
    assign reload = enable && (state_q == LOAD || (state_q == COUNT && cnt_q == '0));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        strobe_d = 1'b0;
        flag_d   = flag_q & ~clr_flag;
        unique case (state_q)
            IDLE:    state_d = enable ? LOAD : IDLE;
            LOAD:    state_d = enable ? COUNT : IDLE;
            COUNT:   state_d = enable ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (reload) begin
            cnt_d    = p - 1'b1;
            period_d = p;
            strobe_d = 1'b1;
            flag_d   = flag_d | clamp_hit;
        end else if (state_q == COUNT) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            strobe_q <= 1'b0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            strobe_q <= strobe_d;
            flag_q   <= flag_d;
            busy_q   <= state_d != IDLE;
        end
    end

    assign dsm_adv    = strobe_q;
    assign div_out    = strobe_q;
    assign period_o   = period_q;
    assign clamp_flag = flag_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_dsm_frac_div.sv
// tb_dsm_frac_div: directed checks of period timing, DSM dithering, clamping, stop and async reset
module tb_dsm_frac_div;
    logic              clk = 1'b0, reset = 1'b0, enable = 1'b0, clr_flag = 1'b0;
    logic [7:0]        n_int = 8'd10;
    logic signed [4:0] dsm_in = 5'sd0;
    logic              dsm_adv, div_out, clamp_flag, busy;
    logic [7:0]        period_o;
    int                errors = 0, checks = 0;

    dsm_frac_div dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .n_int      (n_int),
        .dsm_in     (dsm_in),
        .clr_flag   (clr_flag),
        .dsm_adv    (dsm_adv),
        .div_out    (div_out),
        .period_o   (period_o),
        .clamp_flag (clamp_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // negedges until div_out is seen high; -1 when the budget expires
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_out && n < 400);
        if (!div_out) n = -1;
    endtask

    task automatic start(input logic [7:0] ni, input logic signed [4:0] d, input string tag);
        int n;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_int  = ni;
        dsm_in = d;
        enable = 1'b1;
        wait_pulse(n);
        check({tag, "_latency"}, n, 2);
        check({tag, "_adv"}, int'(dsm_adv), 1);
    endtask

    initial begin
        int n, sum, quiet;
        #2;
        check("rst_div", int'(div_out), 0);
        check("rst_adv", int'(dsm_adv), 0);
        check("rst_period", int'(period_o), 0);
        check("rst_flag", int'(clamp_flag), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // steady integer ratio 10
        start(8'd10, 5'sd0, "int10");
        check("int10_period", int'(period_o), 10);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(n);
            check("int10_interval", n, 10);
            check("int10_adv", int'(dsm_adv), 1);
        end
        check("int10_flag", int'(clamp_flag), 0);
        check("int10_busy", int'(busy), 1);

        // alternating +1/-1 dither around 8
        start(8'd8, 5'sd1, "dith");
        check("dith_period0", int'(period_o), 9);
        dsm_in = -5'sd1;
        sum = 0;
        for (int i = 0; i < 100; i++) begin
            wait_pulse(n);
            if (i < 4) check("dith_interval", n, (i % 2 == 0) ? 9 : 7);
            sum += n;
            dsm_in = -dsm_in;
        end
        check("dith_sum100", sum, 800);

        // low clamp: 4 - 3 = 1 -> 2
        start(8'd4, -5'sd3, "lo");
        check("lo_period", int'(period_o), 2);
        check("lo_flag", int'(clamp_flag), 1);
        @(negedge clk);
        clr_flag = 1'b1;
        @(negedge clk);
        check("lo_interval_pulse", int'(div_out), 1);
        check("lo_set_beats_clr", int'(clamp_flag), 1);
        clr_flag = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
        check("lo_hold_flag", int'(clamp_flag), 1);
        clr_flag = 1'b1;
        @(negedge clk);
        clr_flag = 1'b0;
        check("lo_cleared", int'(clamp_flag), 0);

        // high clamp: 254 + 4 = 258 -> 255
        start(8'd254, 5'sd4, "hi");
        check("hi_period", int'(period_o), 255);
        check("hi_flag", int'(clamp_flag), 1);
        wait_pulse(n);
        check("hi_interval", n, 255);

        // stop with cnt = 3, then restart
        enable = 1'b0;
        @(negedge clk);
        clr_flag = 1'b1;
        @(negedge clk);
        clr_flag = 1'b0;
        start(8'd10, 5'sd0, "stop");
        repeat (6) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_div", int'(div_out), 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet += int'(div_out | dsm_adv | busy);
        end
        check("stop_quiet", quiet, 0);
        check("stop_period_hold", int'(period_o), 10);
        start(8'd10, 5'sd0, "restart");
        wait_pulse(n);
        check("restart_interval", n, 10);

        // asynchronous reset mid-count
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_period", int'(period_o), 0);
        check("arst_div", int'(div_out | dsm_adv), 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        quiet  = 0;
        repeat (5) begin
            @(negedge clk);
            quiet += int'(div_out | busy);
        end
        check("arst_idle", quiet, 0);
        enable = 1'b1;
        wait_pulse(n);
        check("arst_latency", n, 2);
        check("arst_period_new", int'(period_o), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
